// File: rtl/cache_line_arbiter_if.sv
// Line-port bundle between the two L1 caches, the arbiter and physical memory.
// The "slave" modport is the arbiter's view (it serves cache requests and
// drives memory); the "master" modport is the surrounding environment's view.
interface cache_line_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_mem_read;
  logic [ADDR_WIDTH-1:0] i_mem_address;
  logic                  i_mem_resp;
  logic [LINE_WIDTH-1:0] i_mem_rdata;

  logic                  d_mem_read;
  logic                  d_mem_write;
  logic [ADDR_WIDTH-1:0] d_mem_address;
  logic [LINE_WIDTH-1:0] d_mem_wdata;
  logic                  d_mem_resp;
  logic [LINE_WIDTH-1:0] d_mem_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  logic [1:0]            grant;

  modport slave (
    input  i_mem_read, i_mem_address,
    output i_mem_resp, i_mem_rdata,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output d_mem_resp, d_mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata,
    output grant
  );

  modport master (
    output i_mem_read, i_mem_address,
    input  i_mem_resp, i_mem_rdata,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  d_mem_resp, d_mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata,
    input  grant
  );
endinterface

// File: rtl/cache_line_arbiter.sv
// Shares the single physical-memory line port between I-cache and D-cache.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate requests (round-robin on a tie)
// SERVE_I | memory transaction on behalf of the I-cache (always a read)
// SERVE_D | memory transaction on behalf of the D-cache (read or write)
module cache_line_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_line_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1: most recent grant went to D
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic i_req, d_req, pick_d;

  assign i_req  = bus.i_mem_read;
  assign d_req  = bus.d_mem_read | bus.d_mem_write;
  // D wins when it is alone, or on a tie when I was granted last.
  assign pick_d = d_req & ~(i_req & last_d_q);

  // State register plus the transaction latches captured at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for the memory response otherwise
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_d_d = pick_d;
          if (pick_d) begin
            state_d = SERVE_D;
            addr_d  = bus.d_mem_address;
            wdata_d = bus.d_mem_wdata;
            // A simultaneous read+write is treated as a writeback.
            op_wr_d = bus.d_mem_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = bus.i_mem_address;
            op_wr_d = 1'b0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes from registered state/op, resp routed to the owner only
  always_comb begin
    bus.pmem_read    = (state_q != IDLE) & ~op_wr_q;
    bus.pmem_write   = (state_q != IDLE) &  op_wr_q;
    bus.pmem_address = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    bus.pmem_wdata   = wdata_q;
    bus.i_mem_resp   = (state_q == SERVE_I) & bus.pmem_resp;
    bus.d_mem_resp   = (state_q == SERVE_D) & bus.pmem_resp;
    bus.i_mem_rdata  = bus.pmem_rdata;
    bus.d_mem_rdata  = bus.pmem_rdata;
    bus.grant        = {state_q == SERVE_D, state_q == SERVE_I};
  end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Bench for cache_line_arbiter: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against a transaction-level model.
module tb_cache_line_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  localparam logic [LW-1:0] DB = {4{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();

  cache_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic          rsp;
    logic [1:0]    e_gnt;
    logic          e_rd;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    logic          e_ir;
    logic          e_dr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia,
                              input logic dr, input logic dw, input logic [AW-1:0] da,
                              input logic rsp, input logic [1:0] g,
                              input logic erd, input logic ewr, input logic [AW-1:0] ea,
                              input logic [LW-1:0] ewd, input logic eir, input logic edr);
    vec_t v;
    v.i_rd = ir;  v.i_addr = ia; v.d_rd = dr; v.d_wr = dw; v.d_addr = da; v.rsp = rsp;
    v.e_gnt = g;  v.e_rd = erd;  v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd;
    v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_mem_read    = 1'b0;
    bus.i_mem_address = '0;
    bus.d_mem_read    = 1'b0;
    bus.d_mem_write   = 1'b0;
    bus.d_mem_address = '0;
    bus.d_mem_wdata   = '0;
    bus.pmem_resp     = 1'b0;
    bus.pmem_rdata    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: who owns memory, what was latched, who won last.
  logic          m_busy, m_own_d, m_wr, m_last_d;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_data;

  task automatic model_reset();
    m_busy = 1'b0; m_own_d = 1'b0; m_wr = 1'b0; m_last_d = 1'b0;
    m_addr = '0;   m_data = '0;
  endtask

  task automatic model_step(input logic ir, input logic dr, input logic dw,
                            input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [LW-1:0] dwd, input logic rsp);
    logic want_i, want_d, give_d;
    if (m_busy) begin
      if (rsp) m_busy = 1'b0;
    end else begin
      want_i = ir;
      want_d = dr || dw;
      if (want_i || want_d) begin
        if (want_i && want_d) give_d = !m_last_d;
        else                  give_d = want_d;
        m_busy   = 1'b1;
        m_own_d  = give_d;
        m_last_d = give_d;
        if (give_d) begin
          m_wr = dw; m_addr = da; m_data = dwd;
        end else begin
          m_wr = 1'b0; m_addr = ia;
        end
      end
    end
  endtask

  vec_t tbl[$];
  logic [1:0] tie_g[6];

  initial begin
    idle_inputs();

    // ---- reset state ----
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_pmem_address", bus.pmem_address, '0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_i_resp", bus.i_mem_resp, 1'b0);
    chk("rst_d_resp", bus.d_mem_resp, 1'b0);
    rst_n = 1'b1;

    // ---- vector table ----
    // I read 1234 (resp 3 cycles after strobe), D write 4000, tie after D, resp in IDLE.
    tbl.push_back(mk(1,16'h1234,0,0,16'h0000,0, 2'b00,0,0,16'h0000,'0,0,0));
    tbl.push_back(mk(1,16'h1234,0,0,16'h0000,0, 2'b01,1,0,16'h1230,'0,0,0));
    tbl.push_back(mk(1,16'h1234,0,0,16'h0000,0, 2'b01,1,0,16'h1230,'0,0,0));
    tbl.push_back(mk(1,16'h1234,0,0,16'h0000,0, 2'b01,1,0,16'h1230,'0,0,0));
    tbl.push_back(mk(1,16'h1234,0,0,16'h0000,1, 2'b01,1,0,16'h1230,'0,1,0));
    tbl.push_back(mk(0,16'h1234,0,1,16'h4000,0, 2'b00,0,0,16'h1230,'0,0,0));
    tbl.push_back(mk(0,16'h1234,0,1,16'h4000,0, 2'b10,0,1,16'h4000,DB,0,0));
    tbl.push_back(mk(0,16'h1234,0,1,16'h4000,1, 2'b10,0,1,16'h4000,DB,0,1));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,0, 2'b00,0,0,16'h4000,DB,0,0));
    tbl.push_back(mk(1,16'h2222,1,0,16'h5678,0, 2'b00,0,0,16'h4000,DB,0,0));
    tbl.push_back(mk(1,16'h2222,1,0,16'h5678,1, 2'b01,1,0,16'h2220,DB,1,0));
    tbl.push_back(mk(1,16'h2222,1,0,16'h5678,0, 2'b00,0,0,16'h2220,DB,0,0));
    tbl.push_back(mk(1,16'h2222,1,0,16'h5678,1, 2'b10,1,0,16'h5670,DB,0,1));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,1, 2'b00,0,0,16'h5670,DB,0,0));

    do_reset();
    foreach (tbl[k]) begin
      @(negedge clk);
      bus.i_mem_read    = tbl[k].i_rd;
      bus.i_mem_address = tbl[k].i_addr;
      bus.d_mem_read    = tbl[k].d_rd;
      bus.d_mem_write   = tbl[k].d_wr;
      bus.d_mem_address = tbl[k].d_addr;
      bus.d_mem_wdata   = DB;
      bus.pmem_resp     = tbl[k].rsp;
      bus.pmem_rdata    = A5;
      #1;
      chk($sformatf("tbl%0d_grant", k), bus.grant, tbl[k].e_gnt);
      chk($sformatf("tbl%0d_pmem_read", k), bus.pmem_read, tbl[k].e_rd);
      chk($sformatf("tbl%0d_pmem_write", k), bus.pmem_write, tbl[k].e_wr);
      chk($sformatf("tbl%0d_pmem_address", k), bus.pmem_address, tbl[k].e_addr);
      chk($sformatf("tbl%0d_pmem_wdata", k), bus.pmem_wdata, tbl[k].e_wdata);
      chk($sformatf("tbl%0d_i_resp", k), bus.i_mem_resp, tbl[k].e_ir);
      chk($sformatf("tbl%0d_d_resp", k), bus.d_mem_resp, tbl[k].e_dr);
      chk($sformatf("tbl%0d_i_rdata", k), bus.i_mem_rdata, A5);
      chk($sformatf("tbl%0d_d_rdata", k), bus.d_mem_rdata, A5);
    end

    // ---- continuous tie from reset: D, I, D with one IDLE between ----
    tie_g = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.i_mem_read    = 1'b1;
      bus.i_mem_address = 16'h0100;
      bus.d_mem_read    = 1'b1;
      bus.d_mem_address = 16'h0200;
      bus.pmem_resp     = (tie_g[k] != 2'b00);
      #1;
      chk($sformatf("tie%0d_grant", k), bus.grant, tie_g[k]);
      chk($sformatf("tie%0d_i_resp", k), bus.i_mem_resp, tie_g[k] == 2'b01);
      chk($sformatf("tie%0d_d_resp", k), bus.d_mem_resp, tie_g[k] == 2'b10);
    end

    // ---- D arrives during SERVE_I while I drops and changes its address ----
    do_reset();
    @(negedge clk);
    bus.i_mem_read = 1'b1; bus.i_mem_address = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.i_mem_read    = 1'b0;
      bus.i_mem_address = 16'hFFFF;
      bus.d_mem_write   = 1'b1;
      bus.d_mem_address = 16'h8880;
      bus.d_mem_wdata   = DB;
      #1;
      chk("hold_pmem_read", bus.pmem_read, 1'b1);
      chk("hold_pmem_write", bus.pmem_write, 1'b0);
      chk("hold_pmem_address", bus.pmem_address, 16'h1230);
      chk("hold_grant", bus.grant, 2'b01);
    end
    @(negedge clk); bus.pmem_resp = 1'b1; #1;
    chk("wait_i_resp", bus.i_mem_resp, 1'b1);
    chk("wait_d_resp", bus.d_mem_resp, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("wait_idle_grant", bus.grant, 2'b00);
    chk("wait_idle_read", bus.pmem_read, 1'b0);
    @(negedge clk); #1;
    chk("wait_d_grant", bus.grant, 2'b10);
    chk("wait_d_write", bus.pmem_write, 1'b1);
    chk("wait_d_address", bus.pmem_address, 16'h8880);
    @(negedge clk); bus.pmem_resp = 1'b1; #1;
    chk("wait_d_resp_end", bus.d_mem_resp, 1'b1);
    @(negedge clk); bus.pmem_resp = 1'b0; bus.d_mem_write = 1'b0;

    // ---- reset asserted mid SERVE_D ----
    do_reset();
    @(negedge clk);
    bus.d_mem_read = 1'b1; bus.d_mem_address = 16'h3000;
    @(negedge clk); #1;
    chk("mid_rst_pre_grant", bus.grant, 2'b10);
    rst_n = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    chk("mid_rst_grant", bus.grant, 2'b00);
    chk("mid_rst_read", bus.pmem_read, 1'b0);
    chk("mid_rst_write", bus.pmem_write, 1'b0);
    chk("mid_rst_d_resp", bus.d_mem_resp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.d_mem_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("post_rst_i_resp", bus.i_mem_resp, 1'b0);
      chk("post_rst_d_resp", bus.d_mem_resp, 1'b0);
      chk("post_rst_grant", bus.grant, 2'b00);
    end
    bus.pmem_resp = 1'b0;

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.i_mem_read    = 1'($urandom_range(0, 1));
      bus.i_mem_address = 16'($urandom);
      bus.d_mem_read    = 1'($urandom_range(0, 1));
      bus.d_mem_write   = 1'($urandom_range(0, 1));
      bus.d_mem_address = 16'($urandom);
      bus.d_mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      bus.pmem_rdata    = {$urandom, $urandom, $urandom, $urandom};
      bus.pmem_resp     = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      #1;
      chk("rnd_grant", bus.grant, m_busy ? (m_own_d ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_pmem_read", bus.pmem_read, m_busy && !m_wr);
      chk("rnd_pmem_write", bus.pmem_write, m_busy && m_wr);
      chk("rnd_pmem_address", bus.pmem_address, m_addr & 16'hFFF0);
      chk("rnd_pmem_wdata", bus.pmem_wdata, m_data);
      chk("rnd_i_resp", bus.i_mem_resp, m_busy && !m_own_d && bus.pmem_resp);
      chk("rnd_d_resp", bus.d_mem_resp, m_busy && m_own_d && bus.pmem_resp);
      chk("rnd_i_rdata", bus.i_mem_rdata, bus.pmem_rdata);
      chk("rnd_d_rdata", bus.d_mem_rdata, bus.pmem_rdata);
      @(posedge clk);
      model_step(bus.i_mem_read, bus.d_mem_read, bus.d_mem_write,
                 bus.i_mem_address, bus.d_mem_address, bus.d_mem_wdata, bus.pmem_resp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache of the pipelined LC-3b.
- Grants one requester at a time and latches that requester's line address, operation and write data.
- Drives the memory from those latched values and routes the response back to the granted cache only.
- Sits between the two L1 caches and physical memory (or L2); every transfer is one 128-bit line (lc3b_line).

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, line data width (lc3b_line).
- OFFSET_BITS, 4, low address bits forced to zero on pmem_address (16-byte line).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_mem_read  input  1  I-cache line read request; held until i_mem_resp
i_mem_address  input  ADDR_WIDTH  I-cache line address
i_mem_resp  output  1  I-cache transaction complete
i_mem_rdata  output  LINE_WIDTH  read line to I-cache
d_mem_read  input  1  D-cache line read request
d_mem_write  input  1  D-cache line write request (writeback)
d_mem_address  input  ADDR_WIDTH  D-cache line address
d_mem_wdata  input  LINE_WIDTH  D-cache write line
d_mem_resp  output  1  D-cache transaction complete
d_mem_rdata  output  LINE_WIDTH  read line to D-cache
pmem_read  output  1  memory read strobe
pmem_write  output  1  memory write strobe
pmem_address  output  ADDR_WIDTH  latched line address, low OFFSET_BITS zero
pmem_wdata  output  LINE_WIDTH  latched write line
pmem_resp  input  1  memory transaction complete, one-cycle pulse
pmem_rdata  input  LINE_WIDTH  memory read line, valid with pmem_resp
grant  output  2  debug: 00 idle, 01 I-cache, 10 D-cache

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE, last_grant = I.
  - pmem_read, pmem_write, i_mem_resp and d_mem_resp are 0; grant is 00.
  - pmem_address and pmem_wdata latches are 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, requests are i_req = i_mem_read and d_req = d_mem_read | d_mem_write:
  - Only i_req: latch i_mem_address with op = read; next state SERVE_I.
  - Only d_req: latch d_mem_address, d_mem_wdata and op; next state SERVE_D.
    - If d_mem_read and d_mem_write are both high, op = write.
  - Both: round-robin. Grant the requester not equal to last_grant, so the first tie after reset goes to D.
  - Neither: stay in IDLE.
  - Update last_grant on every grant.
- SERVE_x:
  - pmem_read or pmem_write is driven from the latched op (registered, exactly one high).
  - pmem_address and pmem_wdata come from the latches and are stable for the whole transaction.
  - Requester inputs are ignored after grant. Dropping or changing a request mid-transaction does not alter the memory transaction.
  - The other requester waits.
- pmem_resp high in SERVE_x:
  - x_mem_resp = 1 in the same cycle (combinational from state and pmem_resp).
  - Next state IDLE.
  - The strobe is low from the following cycle.
- i_mem_rdata and d_mem_rdata are both driven from pmem_rdata at all times. Only the granted cache sees resp.
- pmem_resp in IDLE is ignored; no client resp is produced.
- Latency:
  - Request sampled at edge N: strobe high after edge N.
  - pmem_resp at cycle M: client resp in cycle M.
  - At least one IDLE cycle between back-to-back transactions.
- A request arriving in the same cycle as pmem_resp is arbitrated in the following IDLE cycle.
- Reset mid-transaction: return to IDLE immediately. The memory transaction is abandoned and memory is reset by the same rst_n.
- Address masking: pmem_address = {latched_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'b0}.

Test Plan:
- I-only read, i_mem_address=16'h1234, memory responds 3 cycles after strobe with 128'hA5..A5:
  - pmem_read high with pmem_address=16'h1230 one cycle after request.
  - i_mem_resp pulses with rdata A5..A5; d_mem_resp stays 0.
- D-only write, address 16'h4000, wdata 128'hDEAD_BEEF repeated:
  - pmem_write high with matching address and data, pmem_read 0.
  - d_mem_resp in the pmem_resp cycle.
  - Strobe low on the next cycle.
- Both caches request continuously from reset:
  - Grant order is D, I, D, I.
  - One IDLE cycle between transactions; grant sequence 10,00,01,00,10.
- D request arrives during SERVE_I:
  - D waits, with no strobe change and pmem_address unchanged.
  - Served after i_mem_resp plus one IDLE cycle.
- I-cache drops i_mem_read and changes address mid-SERVE_I:
  - pmem_read and pmem_address hold their original values until pmem_resp.
- rst_n asserted low mid-SERVE_D:
  - Strobes, resps and grant go to 0 asynchronously.
  - After release, a later pmem_resp in IDLE produces no client resp.
